alu_iter_exec: RTL and testbench
================================

Name: alu_iter_exec

Overview:
- Execute-stage ALU that consumes the 4-bit ALUControl code from the ALU decoder, plus operands SrcA/SrcB, and produces a registered ALUResult and Zero flag.
- Single-cycle ops (add/sub/logic/compare) complete in 1 cycle. Shifts run iteratively, one bit per cycle, to avoid a barrel shifter.
- Valid/ready handshakes on both sides let the controller stall on multi-cycle shifts.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request carries a valid op
- in_ready  output  1  unit can accept a request
- ALUControl  input  4  operation code
- SrcA  input  WIDTH  operand A
- SrcB  input  WIDTH  operand B; SrcB[SHAMT_W-1:0] is the shift amount
- out_valid  output  1  ALUResult/Zero valid
- out_ready  input  1  consumer accepts the result
- ALUResult  output  WIDTH  registered result
- Zero  output  1  high when ALUResult == 0
- busy  output  1  high when state != IDLE

Behaviour:
- Opcodes:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0101 slt (signed)
  - 0110 xor
  - 0111 sll
  - 1000 srl
  - 1001 sra
  - 1100 sltu
  - any other code: result 0, single-cycle path.
- Arithmetic: add/sub wrap modulo 2^WIDTH with no overflow flag. slt/sltu return 1 or 0, zero-extended. sra fills with SrcA[WIDTH-1].
- States: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE). Accept = in_valid && in_ready. ALUControl, SrcA and SrcB are captured at accept; later changes to them are ignored.
- IDLE, on accept:
  - Non-shift op or shift amount 0: compute, load ALUResult, go to DONE. out_valid rises the cycle after accept (latency 1).
  - Shift with amount k>0: load a work register with SrcA and a counter with k, go to SHIFT.
- SHIFT: each cycle, shift the work register 1 bit in the captured direction/fill and decrement the counter. On the cycle the counter goes 1->0, load ALUResult with the final value and go to DONE. out_valid is asserted k+1 cycles after the accept cycle.
- DONE:
  - out_valid = 1.
  - ALUResult and Zero hold stable until out_valid && out_ready.
  - On handshake, return to IDLE. No new accept in the same cycle, so max throughput is 1 op per 2 cycles.
- Zero is derived from the registered ALUResult and is meaningful only while out_valid = 1.
- Reset (any state, including mid-shift): state = IDLE, out_valid = 0, ALUResult = 0, Zero = 1, busy = 0, counter = 0. in_ready = 1 from the first cycle after reset deasserts.
- in_valid while busy: ignored and not queued. The upstream must hold the request until in_ready.
- out_ready while not in DONE: no effect.
- Shift amount uses SrcB[SHAMT_W-1:0] only; upper SrcB bits are ignored (a value of 33 shifts by 1).

Test Plan:
- Reset, then add with SrcA=0x7FFFFFFF, SrcB=0x00000001, out_ready=1 -> out_valid one cycle after accept, ALUResult=0x80000000, Zero=0, in_ready high again the following cycle.
- Sub with SrcA=SrcB=5 -> ALUResult=0, Zero=1, latency 1. Then slt with A=0xFFFFFFFF, B=1 -> 1. Then sltu with the same operands -> 0.
- Sra with A=0x80000000, B=4 -> busy for 4 SHIFT cycles, out_valid 5 cycles after accept, ALUResult=0xF8000000. Srl with the same operands -> 0x08000000. Sll with A=1, B=0x21 -> 0x00000002 after 1 shift cycle.
- Sll with B=0 -> latency 1, ALUResult=SrcA. Unused code 1111 -> ALUResult=0, Zero=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> ALUResult/out_valid stable, in_ready=0, and a new in_valid is not accepted. Raise out_ready -> IDLE on the next cycle.
- Start sra with shamt 31, assert reset on the 10th SHIFT cycle -> next cycle: IDLE, out_valid=0, ALUResult=0, busy=0. A subsequent add 2+3 returns 5 with latency 1.

Source files
------------

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with a registered result and valid/ready handshakes.
// Shifts run one bit per cycle; all other ops complete in a single cycle.
module alu_iter_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         ALUControl,
  input  logic [WIDTH-1:0]   SrcA,
  input  logic [WIDTH-1:0]   SrcB,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   ALUResult,
  output logic               Zero,
  output logic               busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_next;
  logic [3:0]           shift_op;
  logic [WIDTH-1:0]     work, work_step, alu_comb;
  logic [SHAMT_W-1:0]   count, shamt;
  logic                 accept, is_shift, start_shift, last_step;

  assign shamt       = SrcB[SHAMT_W-1:0];
  assign accept      = in_valid && (state == IDLE);
  assign is_shift    = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                       (ALUControl == OP_SRA);
  assign start_shift = is_shift && (shamt != '0);
  assign last_step   = (count == SHAMT_W'(1));

  // Single-cycle results; a zero-amount shift simply passes SrcA through.
  always_comb begin
    alu_comb = '0;
    case (ALUControl)
      OP_ADD:  alu_comb = SrcA + SrcB;
      OP_SUB:  alu_comb = SrcA - SrcB;
      OP_AND:  alu_comb = SrcA & SrcB;
      OP_OR:   alu_comb = SrcA | SrcB;
      OP_XOR:  alu_comb = SrcA ^ SrcB;
      OP_SLT:  alu_comb = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: alu_comb = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLL, OP_SRL, OP_SRA: alu_comb = SrcA;
      default: alu_comb = '0;
    endcase
  end

  always_comb begin
    work_step = work;
    case (shift_op)
      OP_SLL:  work_step = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  work_step = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  work_step = {work[WIDTH-1], work[WIDTH-1:1]};
      default: work_step = work;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = start_shift ? SHIFT : DONE;
      SHIFT:   if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Operands are captured at accept so upstream may change them freely afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      work      <= '0;
      count     <= '0;
      shift_op  <= '0;
      ALUResult <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              work     <= SrcA;
              count    <= shamt;
              shift_op <= ALUControl;
            end else begin
              ALUResult <= alu_comb;
            end
          end
        end
        SHIFT: begin
          work  <= work_step;
          count <= count - SHAMT_W'(1);
          if (last_step) ALUResult <= work_step;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign Zero      = (ALUResult == '0);

endmodule

// File: tb/tb_alu_iter_exec.sv
// Randomized and directed bench for alu_iter_exec against a behavioural model.
module tb_alu_iter_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  localparam int MAX_LAT = 40;

  alu_iter_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_result(input logic [3:0] c, input logic [31:0] a,
                                               input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b % 32);
    sa = a;
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return a ^ b;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return sa >>> sh;
      4'd12:   return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] c, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    if ((c == 4'd7 || c == 4'd8 || c == 4'd9) && sh != 0) return sh + 1;
    return 1;
  endfunction

  // Presents one request from IDLE and waits for out_valid; lat = -1 on timeout.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cyc);
    ALUControl = c; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    ALUControl = 4'($urandom);
    SrcA       = $urandom;
    SrcB       = $urandom;
    lat = 1;
    busy_cyc = 0;
    while (!out_valid && lat < MAX_LAT) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    checks++; if (ALUResult !== 32'd0) begin failures++; $display("[TB] FAIL reset ALUResult: got %h expected 0", ALUResult); end
    checks++; if (Zero !== 1'b1) begin failures++; $display("[TB] FAIL reset Zero: got %b expected 1", Zero); end
  endtask

  task automatic test_directed();
    logic [3:0]  c_t [9];
    logic [31:0] a_t [9];
    logic [31:0] b_t [9];
    logic [31:0] r_t [9];
    int          l_t [9];
    int lat, bc;
    c_t = '{4'b0000, 4'b0001, 4'b0101, 4'b1100, 4'b1001, 4'b1000, 4'b0111, 4'b0111, 4'b1111};
    a_t = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
            32'd1, 32'hDEADBEEF, 32'h1234};
    b_t = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd4, 32'd4, 32'h21, 32'd0, 32'h5678};
    r_t = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'hF8000000, 32'h08000000, 32'd2,
            32'hDEADBEEF, 32'd0};
    l_t = '{1, 1, 1, 1, 5, 5, 2, 1, 1};
    for (int i = 0; i < 9; i++) begin
      issue(c_t[i], a_t[i], b_t[i], lat, bc);
      checks++; if (lat !== l_t[i]) begin failures++; $display("[TB] FAIL directed[%0d] latency: got %0d expected %0d", i, lat, l_t[i]); end
      checks++; if (ALUResult !== r_t[i]) begin failures++; $display("[TB] FAIL directed[%0d] ALUResult: got %h expected %h", i, ALUResult, r_t[i]); end
      checks++; if (Zero !== (r_t[i] == 32'd0)) begin failures++; $display("[TB] FAIL directed[%0d] Zero: got %b expected %b", i, Zero, (r_t[i] == 32'd0)); end
      checks++; if (bc !== l_t[i] - 1) begin failures++; $display("[TB] FAIL directed[%0d] shift cycles: got %0d expected %0d", i, bc, l_t[i] - 1); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL directed[%0d] in_ready in DONE: got %b expected 0", i, in_ready); end
      retire();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL directed[%0d] return to idle: in_ready=%b out_valid=%b expected 1/0", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    int lat, bc;
    logic [31:0] exp;
    exp = model_result(4'd6, 32'hA5A5_0000, 32'h0F0F_F0F0);
    issue(4'd6, 32'hA5A5_0000, 32'h0F0F_F0F0, lat, bc);
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL backpressure latency: got %0d expected 1", lat); end
    ALUControl = 4'd1; SrcA = 32'd9; SrcB = 32'd4; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL backpressure hold[%0d]: out_valid=%b in_ready=%b expected 1/0", i, out_valid, in_ready); end
      checks++; if (ALUResult !== exp) begin failures++; $display("[TB] FAIL backpressure hold[%0d] ALUResult: got %h expected %h", i, ALUResult, exp); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL backpressure release: out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL backpressure no-queue: busy=%b out_valid=%b expected 0/0", busy, out_valid); end
  endtask

  task automatic test_back_to_back();
    int vcount;
    ALUControl = 4'd0; SrcA = 32'd10; SrcB = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        vcount++;
        checks++; if (ALUResult !== 32'd30) begin failures++; $display("[TB] FAIL back_to_back ALUResult: got %h expected 0000001e", ALUResult); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (vcount !== 5) begin failures++; $display("[TB] FAIL back_to_back result count: got %0d expected 5", vcount); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL back_to_back final busy: got %b expected 0", busy); end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] a, b, exp;
    int lat, bc, wait_n;
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 5) == 0) b = a;
      exp = model_result(c, a, b);
      issue(c, a, b, lat, bc);
      checks++; if (lat !== model_latency(c, b)) begin failures++; $display("[TB] FAIL random[%0d] op=%h latency: got %0d expected %0d", i, c, lat, model_latency(c, b)); end
      checks++; if (ALUResult !== exp || Zero !== (exp == 32'd0)) begin failures++; $display("[TB] FAIL random[%0d] op=%h a=%h b=%h: got %h/%b expected %h/%b", i, c, a, b, ALUResult, Zero, exp, (exp == 32'd0)); end
      wait_n = $urandom_range(0, 2);
      repeat (wait_n) @(negedge clk);
      checks++; if (out_valid !== 1'b1 || ALUResult !== exp) begin failures++; $display("[TB] FAIL random[%0d] stall hold: out_valid=%b got %h expected 1/%h", i, out_valid, ALUResult, exp); end
      retire();
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat, bc;
    ALUControl = 4'b1001; SrcA = 32'h8000_0000 | $urandom; SrcB = 32'hFFFF_FFDF | 32'd31;
    in_valid = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_shift busy: busy=%b out_valid=%b expected 1/0", busy, out_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_shift reset state: out_valid=%b busy=%b in_ready=%b expected 0/0/1", out_valid, busy, in_ready); end
    checks++; if (ALUResult !== 32'd0 || Zero !== 1'b1) begin failures++; $display("[TB] FAIL mid_shift reset result: got %h/%b expected 0/1", ALUResult, Zero); end
    issue(4'd0, 32'd2, 32'd3, lat, bc);
    checks++; if (lat !== 1 || ALUResult !== 32'd5) begin failures++; $display("[TB] FAIL mid_shift follow-up add: latency=%0d result=%h expected 1/00000005", lat, ALUResult); end
    retire();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALUControl = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
